lcd_text_responder: RTL and testbench
=====================================

// Module: lcd_text_responder
// PURPOSE
//   HD44780-compatible LCD responder: the device side of the 8-bit parallel LCD bus our text writer drives.
//   Samples LCD_RS/LCD_RW/LCD_EN/LCD_DATA on LCDCLK and decodes the instruction set.
//   Holds a 2x16 DDRAM image, returns busy flag/address and DDRAM data on reads.
//   Used as a synthesizable panel model in simulation and as an on-chip shadow of the display for debug readout.
// PARAMETERS
//   BUSY_CYC   40    LCDCLK cycles busy after a normal instruction or data write
//   BUSY_LONG  1600  LCDCLK cycles busy after clear (0x01) or return-home (0x02/0x03)
// PORTS
//   LCDCLK        in   1  sole clock
//   PRESET        in   1  synchronous reset, active-high
//   LCD_RS        in   1  0=instruction, 1=data
//   LCD_RW        in   1  0=write, 1=read
//   LCD_EN        in   1  enable strobe; transfer commits on its falling edge
//   LCD_DATA      in   8  bus value driven by the host
//   LCD_DATA_OUT  out  8  read data toward the host
//   LCD_DATA_OE   out  1  1 while read data is driven
//   rd_idx        in   5  debug read index into DDRAM image: 0-15 line 1, 16-31 line 2
//   rd_char       out  8  DDRAM image byte at rd_idx, registered, 1-cycle latency
//   busy          out  1  busy flag (BF)
//   disp_ctrl     out  3  {D,C,B} from last display-control instruction
//   drop_err      out  1  sticky: a write arrived while busy; cleared only by reset
// BEHAVIOUR
//   Reset (PRESET=1 at an edge): addr=0x00, I/D=1, disp_ctrl=0, busy=0, drop_err=0, LCD_DATA_OUT=0, LCD_DATA_OE=0, rd_char=0.
//   Reset fills all 32 DDRAM bytes with 0x20. Reset mid-transfer abandons the transfer; no commit.
//   Sampling: EN, RS, RW and DATA are registered every cycle.
//   Falling edge = EN sample 1 followed by EN sample 0. RS/RW/DATA used are the values sampled in the last EN=1 cycle.
//   Commit happens one cycle after the falling edge is detected.
//   Instruction write (RS=0,RW=0) is decoded by the highest set bit:
//     0x01       clear: all DDRAM=0x20, addr=0, I/D=1; busy BUSY_LONG
//     0x02-0x03  home: addr=0; busy BUSY_LONG
//     0x04-0x07  entry mode: I/D=DATA[1]; shift bit S ignored
//     0x08-0x0F  display control: disp_ctrl=DATA[2:0]
//     0x10-0x1F  shift: if DATA[3]=0, cursor moves (addr advance, +1 if DATA[2] else -1); display shift ignored
//     0x20-0x3F  function set: accepted, no state change
//     0x40-0x7F  CGRAM address: accepted, ignored
//     0x80-0xFF  DDRAM address: addr=DATA[6:0]
//     0x00       no-op, but busy is still set
//   All instructions except clear/home set busy for BUSY_CYC.
//   Data write (RS=1,RW=0): if addr maps, DDRAM[map(addr)]=DATA; addr then advances per I/D; busy BUSY_CYC.
//   map(addr): 0x00-0x0F -> 0-15, 0x40-0x4F -> 16-31. Other addresses are not stored, but addr still advances.
//   Address advance wraps 2-line style: inc 0x27->0x40, 0x67->0x00; dec 0x00->0x67, 0x40->0x27.
//   Status read (RS=0,RW=1): while EN sample=1, LCD_DATA_OE=1 and LCD_DATA_OUT={busy,addr}. No state change on the falling edge.
//   Data read (RS=1,RW=1): while EN=1, OE=1 and OUT=DDRAM[map(addr)], or 0x20 if unmapped. Falling edge advances addr; no busy.
//   LCD_DATA_OE drops the cycle after the EN sample goes 0. LCD_DATA_OUT holds its last value.
//   Busy: down-counter loaded at commit; busy=(count!=0). Reads are always serviced while busy.
//   A write committing while busy is dropped (no state change, counter not reloaded) and sets drop_err.
//   Simultaneous debug read and commit to the same index: rd_char returns the pre-write value.
// CONFIGURATION
//   LCD_RESP_BUSY_EN defined: busy timing, write dropping and drop_err behave as above.
//   Not defined: busy tied 0, counter removed, every write accepted, drop_err tied 0, status read returns {1'b0,addr}.
// TESTING
//   Reset, then read all rd_idx 0-31 -> every rd_char=0x20; busy=0; status read returns 0x00.
//   Write instr 0x80, data 0x41 ('A'), wait out busy, data 0x42 -> rd_char[0]=0x41, [1]=0x42, status read=0x02.
//   Instr 0xA7 then data 0x5A twice -> byte not stored at 0x27, addr wraps to 0x40, rd_char[16]=0x5A, status=0x41.
//   Instr 0x04 (I/D=0), instr 0xC0, data 0x31 -> rd_char[16]=0x31, addr becomes 0x27.
//   Instr 0x01, then data 0x55 after 10 cycles -> busy=1, write dropped, drop_err=1; after 1600 cycles busy=0, all bytes 0x20.
//   Write 0x48 at addr 0, then instr 0x80, then data read -> OE high only while EN=1, OUT=0x48, addr advances to 0x01, no busy.

Source files
------------

// File: rtl/lcd_text_responder.sv
// HD44780-style device-side responder for an 8-bit parallel LCD bus with a 2x16 DDRAM shadow image.
// Define LCD_RESP_BUSY_EN to model busy timing, dropping of writes issued while busy, and drop_err.
module lcd_text_responder #(
  parameter int BUSY_CYC  = 40,
  parameter int BUSY_LONG = 1600
) (
  input  logic       LCDCLK,
  input  logic       PRESET,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  input  logic [7:0] LCD_DATA,
  output logic [7:0] LCD_DATA_OUT,
  output logic       LCD_DATA_OE,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_char,
  output logic       busy,
  output logic [2:0] disp_ctrl,
  output logic       drop_err
);

  logic       en_s, en_d, rs_s, rw_s;
  logic [7:0] data_s;
  logic       rs_h, rw_h;
  logic [7:0] data_h;
  logic [6:0] addr;
  logic       inc;
  logic [7:0] ram [32];
  logic       busy_int;
  logic       fall;
  logic       wr_ok;
  logic [7:0] rd_val;

  function automatic logic is_mapped(input logic [6:0] a);
    return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
  endfunction

  function automatic logic [4:0] map_idx(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

  // Two-line address space: line 1 is 0x00-0x27, line 2 is 0x40-0x67.
  function automatic logic [6:0] next_addr(input logic [6:0] a, input logic up);
    if (up) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h00) return 7'h67;
    if (a == 7'h40) return 7'h27;
    return a - 7'd1;
  endfunction

  // Transfer commits on the cycle after the registered EN is seen to fall.
  assign fall  = en_d & ~en_s;
  assign wr_ok = fall & ~rw_h & ~busy_int;

  always_comb begin
    rd_val = {busy_int, addr};
    if (rs_s) rd_val = is_mapped(addr) ? ram[map_idx(addr)] : 8'h20;
  end

`ifdef LCD_RESP_BUSY_EN
  localparam int CW = $clog2(BUSY_LONG + 1);
  logic [CW-1:0] cnt;
  logic          drop_q;
  logic          is_long;

  assign is_long  = ~rs_h & (data_h[7:2] == 6'd0) & (data_h[1:0] != 2'd0);
  assign busy_int = (cnt != '0);
  assign drop_err = drop_q;

  always_ff @(posedge LCDCLK) begin
    if (PRESET) begin
      cnt    <= '0;
      drop_q <= 1'b0;
    end else begin
      if (wr_ok)
        cnt <= is_long ? CW'(BUSY_LONG) : CW'(BUSY_CYC);
      else if (cnt != '0)
        cnt <= cnt - 1'b1;
      if (fall & ~rw_h & busy_int)
        drop_q <= 1'b1;
    end
  end
`else
  assign busy_int = 1'b0;
  assign drop_err = 1'b0;
`endif

  assign busy = busy_int;

  always_ff @(posedge LCDCLK) begin
    if (PRESET) begin
      en_s         <= 1'b0;
      en_d         <= 1'b0;
      rs_s         <= 1'b0;
      rw_s         <= 1'b0;
      data_s       <= 8'h00;
      rs_h         <= 1'b0;
      rw_h         <= 1'b0;
      data_h       <= 8'h00;
      addr         <= 7'h00;
      inc          <= 1'b1;
      disp_ctrl    <= 3'b000;
      LCD_DATA_OUT <= 8'h00;
      LCD_DATA_OE  <= 1'b0;
      rd_char      <= 8'h00;
      for (int i = 0; i < 32; i++) ram[i] <= 8'h20;
    end else begin
      en_s   <= LCD_EN;
      en_d   <= en_s;
      rs_s   <= LCD_RS;
      rw_s   <= LCD_RW;
      data_s <= LCD_DATA;
      if (en_s) begin
        rs_h   <= rs_s;
        rw_h   <= rw_s;
        data_h <= data_s;
      end

      rd_char     <= ram[rd_idx];
      LCD_DATA_OE <= en_s & rw_s;
      if (en_s & rw_s) LCD_DATA_OUT <= rd_val;

      if (fall & rw_h & rs_h)
        addr <= next_addr(addr, inc);

      if (wr_ok) begin
        if (rs_h) begin
          if (is_mapped(addr)) ram[map_idx(addr)] <= data_h;
          addr <= next_addr(addr, inc);
        end else begin
          casez (data_h)
            8'b1???????: addr <= data_h[6:0];
            8'b0001????: if (!data_h[3]) addr <= next_addr(addr, data_h[2]);
            8'b00001???: disp_ctrl <= data_h[2:0];
            8'b000001??: inc <= data_h[1];
            8'b0000001?: addr <= 7'h00;
            8'b00000001: begin
              for (int i = 0; i < 32; i++) ram[i] <= 8'h20;
              addr <= 7'h00;
              inc  <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_text_responder.sv
// Directed bench for lcd_text_responder: vector table of bus writes plus hand-written read/clear/reset sequences.
module tb_lcd_text_responder;

`ifdef LCD_RESP_BUSY_EN
  localparam logic       BUSY_EXP     = 1'b1;
  localparam logic [7:0] EXP_CH0_CLR  = 8'h20;
  localparam logic [7:0] EXP_STAT_CLR = 8'h00;
`else
  localparam logic       BUSY_EXP     = 1'b0;
  localparam logic [7:0] EXP_CH0_CLR  = 8'h55;
  localparam logic [7:0] EXP_STAT_CLR = 8'h01;
`endif

  logic       LCDCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       LCD_RS = 1'b0;
  logic       LCD_RW = 1'b0;
  logic       LCD_EN = 1'b0;
  logic [7:0] LCD_DATA = 8'h00;
  logic [7:0] LCD_DATA_OUT;
  logic       LCD_DATA_OE;
  logic [4:0] rd_idx = 5'd0;
  logic [7:0] rd_char;
  logic       busy;
  logic [2:0] disp_ctrl;
  logic       drop_err;

  int checks = 0;
  int errors = 0;

  lcd_text_responder dut (
    .LCDCLK(LCDCLK), .PRESET(PRESET), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_DATA(LCD_DATA), .LCD_DATA_OUT(LCD_DATA_OUT), .LCD_DATA_OE(LCD_DATA_OE),
    .rd_idx(rd_idx), .rd_char(rd_char), .busy(busy), .disp_ctrl(disp_ctrl), .drop_err(drop_err)
  );

  always #5 LCDCLK = ~LCDCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [4:0] idx;
    logic [7:0] exp_char;
    logic [7:0] exp_stat;
    logic [2:0] exp_disp;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rs, input logic [7:0] d, input logic [4:0] idx,
                              input logic [7:0] ch, input logic [7:0] st, input logic [2:0] dc);
    vec_t v;
    v.rs = rs; v.data = d; v.idx = idx; v.exp_char = ch; v.exp_stat = st; v.exp_disp = dc;
    return v;
  endfunction

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, required %02h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge LCDCLK);
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    LCD_RS = rs; LCD_RW = 1'b0; LCD_DATA = d; LCD_EN = 1'b1;
    cyc(2);
    LCD_EN = 1'b0;
    cyc(4);
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] val, output logic oe_hi,
                          output logic oe_lo, output logic [7:0] held);
    LCD_RS = rs; LCD_RW = 1'b1; LCD_EN = 1'b1;
    cyc(3);
    val = LCD_DATA_OUT; oe_hi = LCD_DATA_OE;
    LCD_EN = 1'b0;
    cyc(2);
    oe_lo = LCD_DATA_OE; held = LCD_DATA_OUT;
    cyc(2);
    LCD_RW = 1'b0;
  endtask

  task automatic status_chk(input string name, input logic [7:0] exp);
    logic [7:0] v, h;
    logic oh, ol;
    bus_read(1'b0, v, oh, ol, h);
    chk8(name, v, exp);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      cyc(1);
      n++;
    end
    chk8("busy_clears", {7'd0, busy}, 8'h00);
  endtask

  task automatic char_chk(input string name, input logic [4:0] idx, input logic [7:0] exp);
    rd_idx = idx;
    cyc(1);
    chk8(name, rd_char, exp);
  endtask

  initial begin
    logic [7:0] v, h;
    logic oh, ol;

    vecs[0]  = mk(0, 8'h80, 0,  8'h20, 8'h00, 3'd0);
    vecs[1]  = mk(1, 8'h41, 0,  8'h41, 8'h01, 3'd0);
    vecs[2]  = mk(1, 8'h42, 1,  8'h42, 8'h02, 3'd0);
    vecs[3]  = mk(0, 8'hA7, 0,  8'h41, 8'h27, 3'd0);
    vecs[4]  = mk(1, 8'h5A, 16, 8'h20, 8'h40, 3'd0);
    vecs[5]  = mk(1, 8'h5A, 16, 8'h5A, 8'h41, 3'd0);
    vecs[6]  = mk(0, 8'h04, 16, 8'h5A, 8'h41, 3'd0);
    vecs[7]  = mk(0, 8'hC0, 16, 8'h5A, 8'h40, 3'd0);
    vecs[8]  = mk(1, 8'h31, 16, 8'h31, 8'h27, 3'd0);
    vecs[9]  = mk(0, 8'h10, 1,  8'h42, 8'h26, 3'd0);
    vecs[10] = mk(0, 8'h14, 1,  8'h42, 8'h27, 3'd0);
    vecs[11] = mk(0, 8'h18, 1,  8'h42, 8'h27, 3'd0);
    vecs[12] = mk(0, 8'h0F, 16, 8'h31, 8'h27, 3'd7);
    vecs[13] = mk(0, 8'h06, 0,  8'h41, 8'h27, 3'd7);
    vecs[14] = mk(0, 8'h14, 0,  8'h41, 8'h40, 3'd7);
    vecs[15] = mk(0, 8'hE7, 0,  8'h41, 8'h67, 3'd7);
    vecs[16] = mk(1, 8'h77, 0,  8'h41, 8'h00, 3'd7);
    vecs[17] = mk(0, 8'h04, 0,  8'h41, 8'h00, 3'd7);
    vecs[18] = mk(0, 8'h10, 0,  8'h41, 8'h67, 3'd7);
    vecs[19] = mk(0, 8'h06, 0,  8'h41, 8'h67, 3'd7);
    vecs[20] = mk(0, 8'h3F, 0,  8'h41, 8'h67, 3'd7);
    vecs[21] = mk(0, 8'h5F, 0,  8'h41, 8'h67, 3'd7);
    vecs[22] = mk(0, 8'h00, 0,  8'h41, 8'h67, 3'd7);
    vecs[23] = mk(0, 8'h0A, 0,  8'h41, 8'h67, 3'd2);
    vecs[24] = mk(0, 8'h02, 0,  8'h41, 8'h00, 3'd2);
    vecs[25] = mk(0, 8'h8F, 15, 8'h20, 8'h0F, 3'd2);
    vecs[26] = mk(1, 8'h4F, 15, 8'h4F, 8'h10, 3'd2);
    vecs[27] = mk(1, 8'h50, 0,  8'h41, 8'h11, 3'd2);
    vecs[28] = mk(0, 8'hCF, 31, 8'h20, 8'h4F, 3'd2);
    vecs[29] = mk(1, 8'h51, 31, 8'h51, 8'h50, 3'd2);

    // Reset state
    cyc(3);
    chk8("rst_out", LCD_DATA_OUT, 8'h00);
    chk8("rst_oe", {7'd0, LCD_DATA_OE}, 8'h00);
    chk8("rst_rd_char", rd_char, 8'h00);
    chk8("rst_busy", {7'd0, busy}, 8'h00);
    chk8("rst_disp", {5'd0, disp_ctrl}, 8'h00);
    chk8("rst_drop", {7'd0, drop_err}, 8'h00);
    PRESET = 1'b0;
    cyc(1);
    for (int i = 0; i < 32; i++) char_chk($sformatf("rst_ddram[%0d]", i), 5'(i), 8'h20);
    status_chk("rst_status", 8'h00);

    for (int i = 0; i < NV; i++) begin
      bus_write(vecs[i].rs, vecs[i].data);
      chk8($sformatf("v%0d_busy_set", i), {7'd0, busy}, {7'd0, BUSY_EXP});
      wait_idle();
      char_chk($sformatf("v%0d_char", i), vecs[i].idx, vecs[i].exp_char);
      chk8($sformatf("v%0d_disp", i), {5'd0, disp_ctrl}, {5'd0, vecs[i].exp_disp});
      status_chk($sformatf("v%0d_status", i), vecs[i].exp_stat);
    end

    // Data read: OE only while EN high, addr advances, no busy
    bus_write(0, 8'h80); wait_idle();
    bus_write(1, 8'h48); wait_idle();
    bus_write(0, 8'h80); wait_idle();
    bus_read(1'b1, v, oh, ol, h);
    chk8("dread_val", v, 8'h48);
    chk8("dread_oe_hi", {7'd0, oh}, 8'h01);
    chk8("dread_oe_lo", {7'd0, ol}, 8'h00);
    chk8("dread_out_held", h, 8'h48);
    chk8("dread_no_busy", {7'd0, busy}, 8'h00);
    status_chk("dread_status", 8'h01);

    bus_write(0, 8'hA0); wait_idle();
    bus_read(1'b1, v, oh, ol, h);
    chk8("dread_unmapped", v, 8'h20);
    status_chk("dread_unmapped_status", 8'h21);

    // Debug read racing a commit to the same index sees the old byte first
    bus_write(0, 8'h85); wait_idle();
    char_chk("race_pre", 5'd5, 8'h20);
    LCD_RS = 1'b1; LCD_RW = 1'b0; LCD_DATA = 8'h66; LCD_EN = 1'b1;
    cyc(2);
    LCD_EN = 1'b0;
    cyc(2);
    chk8("race_commit_cycle", rd_char, 8'h20);
    cyc(1);
    chk8("race_after", rd_char, 8'h66);
    cyc(2);
    wait_idle();

    // Clear, then a data write shortly afterwards
    bus_write(0, 8'h01);
    cyc(4);
    bus_write(1, 8'h55);
    chk8("clr_busy", {7'd0, busy}, {7'd0, BUSY_EXP});
    chk8("clr_drop_err", {7'd0, drop_err}, {7'd0, BUSY_EXP});
    bus_read(1'b0, v, oh, ol, h);
    chk8("clr_status_bf", {7'd0, v[7]}, {7'd0, BUSY_EXP});
    wait_idle();
    status_chk("clr_status", EXP_STAT_CLR);
    char_chk("clr_ddram[0]", 5'd0, EXP_CH0_CLR);
    for (int i = 1; i < 32; i++) char_chk($sformatf("clr_ddram[%0d]", i), 5'(i), 8'h20);

    // Reset in the middle of a transfer: nothing commits
    bus_write(0, 8'h80); wait_idle();
    LCD_RS = 1'b1; LCD_RW = 1'b0; LCD_DATA = 8'h99; LCD_EN = 1'b1;
    cyc(2);
    PRESET = 1'b1;
    cyc(1);
    LCD_EN = 1'b0;
    cyc(2);
    PRESET = 1'b0;
    cyc(3);
    char_chk("midrst_ddram0", 5'd0, 8'h20);
    chk8("midrst_drop", {7'd0, drop_err}, 8'h00);
    chk8("midrst_busy", {7'd0, busy}, 8'h00);
    status_chk("midrst_status", 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
